// File: rtl/dmem_access_unit.sv
// Load/store initiator for the byte-addressed data memory. Byte and halfword stores use read-modify-write.
// Optional misalignment trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_base,
    input  logic [31:0]           req_offset,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [31:0]           mem_read_data,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [31:0]           mem_write_data
);

    typedef enum logic [2:0] {IDLE, LD_RD, RMW_RD, ST_WR, RESP} state_t;

    state_t      state_p0, state_nxt;
    logic [31:0] ea_p0;
    logic [2:0]  funct3_p0;
    logic [31:0] wr_word_p0;
    logic [31:0] rdata_p0;
    logic        accept;
    logic        trap_c;
    logic [31:0] ea_c;
    logic [2:0]  funct3_c;

    // Unsupported width codes collapse to a full-word access.
    function automatic logic [2:0] norm_funct3(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: norm_funct3 = f3;
            default:                                norm_funct3 = 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (f3)
            3'b000:  extend_load = 32'(b);
            3'b001:  extend_load = 32'(h);
            3'b100:  extend_load = {24'b0, w[7:0]};
            3'b101:  extend_load = {16'b0, w[15:0]};
            default: extend_load = w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] mem_w, input logic [31:0] wd,
                                                input logic [2:0] f3);
        if (f3[0])
            merge_store = {mem_w[31:16], wd[15:0]};
        else
            merge_store = {mem_w[31:8], wd[7:0]};
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_p0;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [31:0] ea);
        case (f3[1:0])
            2'b01:   is_misaligned = ea[0];
            2'b10:   is_misaligned = (ea[1:0] != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    assign trap_c   = is_misaligned(funct3_c, ea_c);
    assign resp_err = err_p0;
`else
    assign trap_c   = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign ea_c       = req_base + req_offset;
    assign funct3_c   = norm_funct3(req_funct3);
    assign accept     = req_valid && (state_p0 == IDLE);
    assign resp_rdata = rdata_p0;

    always_comb begin
        state_nxt    = state_p0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state_p0)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (trap_c)
                        state_nxt = RESP;
                    else if (!req_store)
                        state_nxt = LD_RD;
                    else if (funct3_c[1:0] == 2'b10)
                        state_nxt = ST_WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            LD_RD: begin
                mem_read_en = 1'b1;
                state_nxt   = RESP;
            end
            RMW_RD: begin
                mem_read_en = 1'b1;
                state_nxt   = ST_WR;
            end
            ST_WR: begin
                mem_write_en = 1'b1;
                state_nxt    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses and write data are gated so idle/reset outputs read as zero.
    assign mem_read_addr  = mem_read_en  ? ea_p0[ADDR_WIDTH-1:0] : '0;
    assign mem_write_addr = mem_write_en ? ea_p0[ADDR_WIDTH-1:0] : '0;
    assign mem_write_data = mem_write_en ? wr_word_p0 : '0;

    // p0: request capture and read-modify-write merge (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            ea_p0      <= ea_c;
            funct3_p0  <= funct3_c;
            wr_word_p0 <= req_wdata;
        end else if (state_p0 == RMW_RD) begin
            wr_word_p0 <= merge_store(mem_read_data, wr_word_p0, funct3_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            rdata_p0 <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_p0   <= 1'b0;
`endif
        end else begin
            state_p0 <= state_nxt;
            if (accept) begin
                rdata_p0 <= trap_c ? ea_c : 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
                err_p0   <= trap_c;
`endif
            end else if (state_p0 == LD_RD) begin
                rdata_p0 <= extend_load(mem_read_data, funct3_p0);
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Table-driven bench for dmem_access_unit with a byte-array memory model and response scoreboard.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_read_addr, mem_write_addr, mem_read_data, mem_write_data;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    // 256-byte memory model; addresses alias modulo 256, which also models addr+i wrap.
    logic [7:0]  mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_a;
    logic [31:0] pre_w;

    assign mem_read_data = {mem[mem_read_addr[7:0] + 8'd3], mem[mem_read_addr[7:0] + 8'd2],
                            mem[mem_read_addr[7:0] + 8'd1], mem[mem_read_addr[7:0]]};

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_a]        <= pre_w[7:0];
            mem[pre_a + 8'd1] <= pre_w[15:8];
            mem[pre_a + 8'd2] <= pre_w[23:16];
            mem[pre_a + 8'd3] <= pre_w[31:24];
        end else if (mem_write_en) begin
            mem[mem_write_addr[7:0]]        <= mem_write_data[7:0];
            mem[mem_write_addr[7:0] + 8'd1] <= mem_write_data[15:8];
            mem[mem_write_addr[7:0] + 8'd2] <= mem_write_data[23:16];
            mem[mem_write_addr[7:0] + 8'd3] <= mem_write_data[31:24];
        end
    end

    function automatic logic [31:0] peek(input logic [7:0] a);
        peek = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    typedef struct {
        string       name;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] base, off, wdata, pre_addr, pre;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          rd_cyc, wr_cyc, resp_cyc;
        logic [31:0] exp_wdata;
        int          stall;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];
    int    checks = 0;
    int    passes = 0;

    function automatic vec_t mk(input string nm, input logic st, input logic [2:0] f3,
                                input logic [31:0] base, input logic [31:0] off,
                                input logic [31:0] wdata, input logic [31:0] pa,
                                input logic [31:0] pw, input logic [31:0] erd, input logic err,
                                input int rd, input int wr, input int resp,
                                input logic [31:0] ewd, input int stall);
        vec_t v;
        v.name = nm; v.store = st; v.f3 = f3; v.base = base; v.off = off; v.wdata = wdata;
        v.pre_addr = pa; v.pre = pw; v.exp_rdata = erd; v.exp_err = err;
        v.rd_cyc = rd; v.wr_cyc = wr; v.resp_cyc = resp; v.exp_wdata = ewd; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        pre_en = 1'b1; pre_a = a[7:0]; pre_w = w;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int rd_n, wr_n, rd_c, wr_c, resp_c, both;
        logic [31:0] ea, wa, wd;
        resp_t exp;
        ea = v.base + v.off;
        rd_n = 0; wr_n = 0; rd_c = 0; wr_c = 0; resp_c = 0; both = 0; wa = 0; wd = 0;
        preload(v.pre_addr, v.pre);
        @(negedge clk);
        chk({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
        req_base = v.base; req_offset = v.off; req_wdata = v.wdata;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_read_en) begin
                rd_n++; rd_c = c;
                chk({v.name, " read addr"}, mem_read_addr, ea);
            end
            if (mem_write_en) begin
                wr_n++; wr_c = c; wa = mem_write_addr; wd = mem_write_data;
            end
            if (mem_read_en && mem_write_en) both++;
            if (resp_valid) begin
                resp_c = c;
                break;
            end
        end
        chk({v.name, " read cycle"}, 32'(rd_n > 1 ? 99 : rd_c), 32'(v.rd_cyc));
        chk({v.name, " write cycle"}, 32'(wr_n > 1 ? 99 : wr_c), 32'(v.wr_cyc));
        chk({v.name, " enables exclusive"}, 32'(both), 32'd0);
        chk({v.name, " resp cycle"}, 32'(resp_c), 32'(v.resp_cyc));
        if (v.wr_cyc != 0) begin
            chk({v.name, " write addr"}, wa, ea);
            chk({v.name, " write data"}, wd, v.exp_wdata);
            chk({v.name, " memory after"}, peek(ea[7:0]), v.exp_wdata);
        end
        if (resp_c == 0) begin
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        exp = sb.pop_front();
        chk({v.name, " resp_rdata"}, resp_rdata, exp.rdata);
        chk({v.name, " resp_err"}, 32'(resp_err), 32'(exp.err));
        chk({v.name, " req_ready busy"}, 32'(req_ready), 32'd0);
        for (int k = 0; k < v.stall; k++) begin
            @(negedge clk);
            chk({v.name, " stall valid"}, 32'(resp_valid), 32'd1);
            chk({v.name, " stall rdata"}, resp_rdata, exp.rdata);
            chk({v.name, " stall req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({v.name, " resp dropped"}, 32'(resp_valid), 32'd0);
        chk({v.name, " req_ready back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, " resp_rdata"}, resp_rdata, 32'd0);
        chk({nm, " resp_err"}, 32'(resp_err), 32'd0);
        chk({nm, " enables"}, {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk({nm, " addr/data"}, mem_read_addr | mem_write_addr | mem_write_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int wcount;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b010;
        req_base = 0; req_offset = 0; req_wdata = 0; resp_ready = 1'b0;

        vecs.push_back(mk("LW", 0, 3'b010, 32'h100, 0, 0, 32'h100, 32'h12347F80,
                          32'h12347F80, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("LB", 0, 3'b000, 32'h100, 0, 0, 32'h100, 32'h12347F80,
                          32'hFFFFFF80, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("LBU", 0, 3'b100, 32'h100, 0, 0, 32'h100, 32'h12347F80,
                          32'h00000080, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("LH", 0, 3'b001, 32'h100, 0, 0, 32'h100, 32'h12347F80,
                          32'h00007F80, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("LH neg", 0, 3'b001, 32'h1F0, 32'h10, 0, 32'h200, 32'h00008001,
                          32'hFFFF8001, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk("LHU", 0, 3'b101, 32'h200, 0, 0, 32'h200, 32'h00008001,
                          32'h00008001, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("SB", 1, 3'b000, 32'h100, 0, 32'hAABBCCDD, 32'h100, 32'h78563412,
                          32'h0, 0, 1, 2, 3, 32'h785634DD, 0));
        vecs.push_back(mk("SH", 1, 3'b001, 32'h108, 32'hFFFFFFFC, 32'h1234ABCD, 32'h104,
                          32'h78563412, 32'h0, 0, 1, 2, 3, 32'h7856ABCD, 2));
        vecs.push_back(mk("SW wrap", 1, 3'b010, 32'hFFFFFFF0, 32'h14, 32'hDEADBEEF, 32'h4,
                          32'h0, 32'h0, 0, 0, 1, 2, 32'hDEADBEEF, 5));
        vecs.push_back(mk("funct3 011", 0, 3'b011, 32'h100, 0, 0, 32'h100, 32'h11223344,
                          32'h11223344, 0, 1, 0, 2, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("LHU 101", 0, 3'b101, 32'h100, 1, 0, 32'h100, 32'h12347F80,
                          32'h101, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("LW 102", 0, 3'b010, 32'h100, 2, 0, 32'h102, 32'h55667788,
                          32'h102, 1, 0, 0, 1, 0, 2));
        vecs.push_back(mk("LW FFFE", 0, 3'b010, 0, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 32'hCAFEF00D,
                          32'hFFFFFFFE, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("SH 103", 1, 3'b001, 32'h103, 0, 32'h0000BEEF, 32'h103, 32'h44332211,
                          32'h103, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("LB odd ok", 0, 3'b000, 32'h103, 0, 0, 32'h103, 32'h44332211,
                          32'h00000011, 0, 1, 0, 2, 0, 0));
`else
        vecs.push_back(mk("LHU 101", 0, 3'b101, 32'h100, 1, 0, 32'h100, 32'h12347F80,
                          32'h0000347F, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("LW 102", 0, 3'b010, 32'h100, 2, 0, 32'h102, 32'h55667788,
                          32'h55667788, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("LW FFFE", 0, 3'b010, 0, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 32'hCAFEF00D,
                          32'hCAFEF00D, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk("SH 103", 1, 3'b001, 32'h103, 0, 32'h0000BEEF, 32'h103, 32'h44332211,
                          32'h0, 0, 1, 2, 3, 32'h4433BEEF, 0));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while the halfword store is in its read phase must leave memory untouched.
        preload(32'h100, 32'h11111111);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_base = 32'h100; req_offset = 0; req_wdata = 32'h00002222;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst-mid read phase", 32'(mem_read_en), 32'd1);
        rst = 1'b1;
        wcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_write_en) wcount++;
            rst = 1'b0;
        end
        chk("rst-mid no write", 32'(wcount), 32'd0);
        chk("rst-mid memory", peek(8'h00), 32'h11111111);
        chk_reset_outputs("rst-mid");

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
